// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg: shared widths and constants for the fetch front end.
// Holds word width, reset PC, PC step and default queue depth.
package ifetch_queue_pkg;

  localparam int IFQ_WORD_WIDTH = 32;
  localparam int IFQ_DEPTH = 4;

  typedef logic [IFQ_WORD_WIDTH-1:0] word_t;

  localparam word_t INST_RESET_PC = 32'h0000_0000;
  localparam word_t PC_INC = 32'd4;

endpackage

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: memory request/response, redirect and core-side handshakes.
// master = fetch unit (drives mem_req_*, inst_*); slave = memory + core.
interface ifetch_queue_if
  import ifetch_queue_pkg::*;
#(
  parameter int W = IFQ_WORD_WIDTH
);

  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [W-1:0] mem_req_addr;
  logic         mem_resp_valid;
  logic [W-1:0] mem_resp_data;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;
  logic         inst_valid;
  logic         inst_ready;
  logic [W-1:0] inst_code;
  logic [W-1:0] inst_pc;
  logic [W-1:0] inst_pc4;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    output inst_code,
    output inst_pc,
    output inst_pc4,
    input  inst_ready
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    input  inst_code,
    input  inst_pc,
    input  inst_pc4,
    output inst_ready
  );

endinterface

// File: rtl/ifetch_queue_sync_fifo.sv
// sync_fifo: power-of-two FIFO with flush; head is read combinationally.
// Ports: push/wdata, pop/rdata, flush, full, empty, count.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rdata = mem[rd_ptr];

  // a full FIFO still accepts a push when the head leaves
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: owns fetch PC, issues in-order word reads, queues results.
// Ports: clk, rst_n, bus (mem req/resp, redirect, inst handshake).
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int WORD_WIDTH = IFQ_WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0] RESET_PC = INST_RESET_PC
) (
  input logic clk,
  input logic rst_n,
  ifetch_queue_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W  = WORD_WIDTH;
  localparam logic [W-1:0] INC   = W'(PC_INC);
  localparam logic [W-1:0] ALIGN = ~W'(3);

  logic         run;
  logic [W-1:0] fetch_pc;
  logic [CW-1:0] drop_count;
  logic [CW-1:0] in_flight;
  logic [CW-1:0] in_flight_nx;
  logic [CW-1:0] q_count;
  logic          q_empty;
  logic          unused_q_full;
  logic [2*W-1:0] q_head;
  logic          tag_empty;
  logic          tag_full;
  logic [W-1:0]  tag_pc;

  logic redirect;
  logic credit;
  logic req_valid;
  logic req_fire;
  logic resp_ok;
  logic drop_now;
  logic q_push;
  logic q_pop;

  assign redirect = bus.redirect_valid;

  // queued + in-flight never exceeds DEPTH, so every
  // response is guaranteed a free slot on arrival
  assign credit =
    ({1'b0, q_count} + {1'b0, in_flight}) < (CW + 1)'(DEPTH);

  assign req_valid = run & credit & ~tag_full & ~redirect;
  assign req_fire  = req_valid & bus.mem_req_ready;

  // a response with nothing outstanding is ignored
  assign resp_ok  = bus.mem_resp_valid & ~tag_empty;
  assign drop_now = resp_ok & (drop_count != '0);
  assign q_push   = resp_ok & ~drop_now & ~redirect;
  assign q_pop    = ~q_empty & bus.inst_ready;

  assign in_flight_nx =
    in_flight + CW'(req_fire) - CW'(resp_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run        <= 1'b0;
      fetch_pc   <= RESET_PC;
      drop_count <= '0;
    end else begin
      run <= 1'b1;
      if (redirect) begin
        fetch_pc   <= bus.redirect_pc & ALIGN;
        // everything still outstanding belongs to the old path
        drop_count <= in_flight_nx;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + INC;
        if (drop_now) drop_count <= drop_count - 1'b1;
      end
    end
  end

  // tags are never flushed: dropped responses still retire theirs
  sync_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_fire),
    .wdata (fetch_pc),
    .pop   (resp_ok),
    .rdata (tag_pc),
    .flush (1'b0),
    .full  (tag_full),
    .empty (tag_empty),
    .count (in_flight)
  );

  sync_fifo #(
    .WIDTH (2 * W),
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .wdata ({tag_pc, bus.mem_resp_data}),
    .pop   (q_pop),
    .rdata (q_head),
    .flush (redirect),
    .full  (unused_q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign bus.mem_req_valid = req_valid;
  assign bus.mem_req_addr  = run ? fetch_pc : '0;

  assign bus.inst_valid = ~q_empty;
  assign bus.inst_code  = q_empty ? '0 : q_head[W-1:0];
  assign bus.inst_pc    = q_empty ? '0 : q_head[2*W-1:W];
  assign bus.inst_pc4   =
    q_empty ? '0 : q_head[2*W-1:W] + INC;

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: vectors, directed corner cases and random traffic
// checked against a queue-level model of fetch/deliver/redirect.
module tb_ifetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  ifetch_queue_if #(.W(32)) b();

  ifetch_queue #(
    .DEPTH      (DEPTH),
    .WORD_WIDTH (32),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    bit          drop;
  } fl_t;

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          irdy;
    bit          rv;
    logic [31:0] addr;
    bit          iv;
    logic [31:0] pc;
  } vec_t;

  pend_t       pend[$];
  fl_t         infl[$];
  logic [31:0] rq[$];
  logic [31:0] exp_fetch;
  int          cyc;
  int          lat;
  int          jit;
  int          last_due;
  int          errors;
  int          checks;
  bit          rdy_in;
  bit          irdy_in;
  bit          redir_in;
  logic [31:0] rpc_in;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // one clock: drive inputs, compare against model, advance model
  task automatic cycle();
    bit          resp;
    bit          fire;
    bit          erv;
    int          d;
    fl_t         e;
    pend_t       p;
    @(negedge clk);
    resp = pend.size() > 0 && pend[0].due <= cyc;
    b.mem_req_ready  = rdy_in;
    b.inst_ready     = irdy_in;
    b.redirect_valid = redir_in;
    b.redirect_pc    = rpc_in;
    b.mem_resp_valid = resp;
    b.mem_resp_data  = resp ? memf(pend[0].addr) : 32'h0;
    #1;
    erv = (rq.size() + infl.size() < DEPTH) && !redir_in;
    chk("req_valid", b.mem_req_valid, erv);
    if (erv) chk("req_addr", b.mem_req_addr, exp_fetch);
    chk("inst_valid", b.inst_valid, rq.size() > 0);
    if (rq.size() > 0) begin
      chk("inst_pc", b.inst_pc, rq[0]);
      chk("inst_code", b.inst_code, memf(rq[0]));
      chk("inst_pc4", b.inst_pc4, rq[0] + 32'd4);
    end
    fire = b.mem_req_valid && rdy_in;
    if (rq.size() > 0 && irdy_in) void'(rq.pop_front());
    if (resp) begin
      assert (infl.size() > 0)
        else $error("response with nothing in flight");
      if (infl.size() > 0) begin
        e = infl.pop_front();
        if (!e.drop && !redir_in) rq.push_back(e.pc);
      end
      void'(pend.pop_front());
    end
    if (fire) begin
      e.pc = exp_fetch;
      e.drop = 1'b0;
      infl.push_back(e);
      d = cyc + lat + int'($urandom_range(0, jit));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      p.addr = b.mem_req_addr;
      p.due = d;
      pend.push_back(p);
      exp_fetch += 32'd4;
    end
    if (redir_in) begin
      rq.delete();
      foreach (infl[i]) infl[i].drop = 1'b1;
      exp_fetch = rpc_in & ~32'h3;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_req_valid", b.mem_req_valid, 0);
    chk("rst_req_addr", b.mem_req_addr, 0);
    chk("rst_inst_valid", b.inst_valid, 0);
    chk("rst_inst_code", b.inst_code, 0);
    chk("rst_inst_pc", b.inst_pc, 0);
    chk("rst_inst_pc4", b.inst_pc4, 0);
    pend.delete();
    infl.delete();
    rq.delete();
    exp_fetch = RESET_PC;
    last_due = 0;
    redir_in = 1'b0;
    b.redirect_valid = 1'b0;
    b.mem_resp_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt[16];
    bit          hit;
    bit          seen;
    logic [31:0] got[$];

    errors = 0;
    checks = 0;
    cyc = 0;
    lat = 1;
    jit = 0;
    last_due = 0;
    rdy_in = 1'b0;
    irdy_in = 1'b0;
    redir_in = 1'b0;
    rpc_in = 32'h0;
    exp_fetch = RESET_PC;
    b.mem_req_ready = 1'b0;
    b.inst_ready = 1'b0;
    b.redirect_valid = 1'b0;
    b.redirect_pc = 32'h0;
    b.mem_resp_valid = 1'b0;
    b.mem_resp_data = 32'h0;

    // rst rdy irdy | rv addr iv pc   (1-cycle memory)
    vt[0]  = '{1, 1, 1, 1, 32'h00, 0, 32'h00};
    vt[1]  = '{0, 1, 1, 1, 32'h04, 0, 32'h00};
    vt[2]  = '{0, 1, 1, 1, 32'h08, 1, 32'h00};
    vt[3]  = '{0, 1, 1, 1, 32'h0C, 1, 32'h04};
    vt[4]  = '{0, 1, 1, 1, 32'h10, 1, 32'h08};
    vt[5]  = '{1, 1, 0, 1, 32'h00, 0, 32'h00};
    vt[6]  = '{0, 1, 0, 1, 32'h04, 0, 32'h00};
    vt[7]  = '{0, 1, 0, 1, 32'h08, 1, 32'h00};
    vt[8]  = '{0, 1, 0, 1, 32'h0C, 1, 32'h00};
    vt[9]  = '{0, 1, 0, 0, 32'h00, 1, 32'h00};
    vt[10] = '{0, 1, 0, 0, 32'h00, 1, 32'h00};
    vt[11] = '{0, 1, 1, 0, 32'h00, 1, 32'h00};
    vt[12] = '{0, 1, 1, 1, 32'h10, 1, 32'h04};
    vt[13] = '{0, 1, 1, 1, 32'h14, 1, 32'h08};
    vt[14] = '{0, 1, 1, 1, 32'h18, 1, 32'h0C};
    vt[15] = '{0, 1, 1, 1, 32'h1C, 1, 32'h10};

    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      rdy_in = vt[i].rdy;
      irdy_in = vt[i].irdy;
      cycle();
      chk($sformatf("vec%0d_rv", i), b.mem_req_valid, vt[i].rv);
      if (vt[i].rv)
        chk($sformatf("vec%0d_addr", i), b.mem_req_addr, vt[i].addr);
      chk($sformatf("vec%0d_iv", i), b.inst_valid, vt[i].iv);
      if (vt[i].iv) begin
        chk($sformatf("vec%0d_pc", i), b.inst_pc, vt[i].pc);
        chk($sformatf("vec%0d_code", i), b.inst_code, memf(vt[i].pc));
        chk($sformatf("vec%0d_pc4", i), b.inst_pc4, vt[i].pc + 32'd4);
      end
    end

    // three slow fetches in flight, then a misaligned redirect
    do_reset();
    lat = 4;
    rdy_in = 1'b1;
    irdy_in = 1'b1;
    redir_in = 1'b1;
    rpc_in = 32'h20;
    cycle();
    redir_in = 1'b0;
    repeat (3) cycle();
    redir_in = 1'b1;
    rpc_in = 32'h102;
    cycle();
    chk("a_redir_rv", b.mem_req_valid, 0);
    redir_in = 1'b0;
    cycle();
    chk("a_flush_iv", b.inst_valid, 0);
    chk("a_next_addr", b.mem_req_addr, 32'h100);
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      cycle();
      if (b.inst_valid) begin
        hit = 1'b1;
        chk("a_first_pc", b.inst_pc, 32'h100);
      end
    end
    chk("a_first_seen", hit, 1);

    // redirect together with a response and a pop, into the wrap
    lat = 1;
    repeat (6) cycle();
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (rq.size() > 0 && pend.size() > 0 && pend[0].due <= cyc) begin
        hit = 1'b1;
        redir_in = 1'b1;
        rpc_in = 32'hFFFF_FFF8;
      end
      cycle();
      redir_in = 1'b0;
    end
    chk("b_found", hit, 1);
    seen = 1'b0;
    got.delete();
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i == 0) chk("b_flush_iv", b.inst_valid, 0);
      if (b.mem_req_valid && rdy_in) got.push_back(b.mem_req_addr);
      if (b.inst_valid && b.inst_pc == 32'hFFFF_FFFC) begin
        seen = 1'b1;
        chk("c_wrap_pc4", b.inst_pc4, 32'h0);
      end
    end
    chk("c_wrap_seen", seen, 1);
    if (got.size() >= 3) begin
      chk("c_req0", got[0], 32'hFFFF_FFF8);
      chk("c_req1", got[1], 32'hFFFF_FFFC);
      chk("c_req2", got[2], 32'h0);
    end else begin
      chk("c_req_count", got.size(), 3);
    end

    // reset with two queued and two in flight
    do_reset();
    lat = 3;
    rdy_in = 1'b1;
    irdy_in = 1'b0;
    repeat (5) cycle();
    do_reset();
    lat = 1;
    irdy_in = 1'b1;
    cycle();
    chk("d_addr", b.mem_req_addr, RESET_PC);
    chk("d_rv", b.mem_req_valid, 1);
    chk("d_iv", b.inst_valid, 0);
    repeat (8) cycle();

    // random traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if (k % 500 == 0) begin
        lat = $urandom_range(1, 4);
        jit = $urandom_range(0, 2);
      end
      rdy_in = ($urandom % 4) != 0;
      irdy_in = ($urandom % 3) != 0;
      redir_in = ($urandom % 32) == 0;
      if ($urandom % 4 == 0)
        rpc_in = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
      else
        rpc_in = $urandom & 32'h0000_3FFF;
      cycle();
    end
    redir_in = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
